// File: rtl/fetch_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : fetch_stage                                                 |
// | Brief   : PC owner, imem address driver and IF/ID pipeline register   |
// |           with stall, redirect and saturating fetch/flush counters.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module fetch_stage #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [DATA_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instruction_if_id,
    output logic [DATA_W-1:0] updated_pc_if_id,
    output logic [DATA_W-1:0] current_pc_if_id,
    output logic              valid_if_id,
    output logic [DATA_W-1:0] fetch_count,
    output logic [DATA_W-1:0] flush_count
);

    localparam logic [DATA_W-1:0] c_pc_step  = DATA_W'(PC_STEP);
    localparam logic [DATA_W-1:0] c_low_mask = DATA_W'(3);

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_updated_pc;
    logic [DATA_W-1:0] r_current_pc;
    logic              r_valid;
    logic [DATA_W-1:0] r_fetch_count;
    logic [DATA_W-1:0] r_flush_count;

    logic [DATA_W-1:0] w_pc_seq;
    logic [DATA_W-1:0] w_redirect_target;

    assign w_pc_seq          = r_pc + c_pc_step;
    // Targets are word aligned: the two low bits are dropped, never used.
    assign w_redirect_target = redirect_pc & ~c_low_mask;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_updated_pc  <= '0;
            r_current_pc  <= '0;
            r_valid       <= 1'b0;
            r_fetch_count <= '0;
            r_flush_count <= '0;
        end else if (enable) begin
            if (redirect_valid) begin
                // Wrong-path word is discarded even under stall.
                r_pc         <= w_redirect_target;
                r_instr      <= '0;
                r_updated_pc <= '0;
                r_current_pc <= '0;
                r_valid      <= 1'b0;
                if (r_flush_count != '1) begin
                    r_flush_count <= r_flush_count + 1'b1;
                end
            end else if (!stall) begin
                r_pc         <= w_pc_seq;
                r_instr      <= imem_rdata;
                r_updated_pc <= w_pc_seq;
                r_current_pc <= r_pc;
                r_valid      <= 1'b1;
                if (r_fetch_count != '1) begin
                    r_fetch_count <= r_fetch_count + 1'b1;
                end
            end
        end
    end

    assign imem_addr         = r_pc;
    assign instruction_if_id = r_instr;
    assign updated_pc_if_id  = r_updated_pc;
    assign current_pc_if_id  = r_current_pc;
    assign valid_if_id       = r_valid;
    assign fetch_count       = r_fetch_count;
    assign flush_count       = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_fetch_stage                                              |
// | Brief   : Randomized scoreboard bench for fetch_stage, plus a narrow  |
// |           8-bit instance used to reach counter saturation quickly.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        enable;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_if_id;
    logic [31:0] updated_pc_if_id;
    logic [31:0] current_pc_if_id;
    logic        valid_if_id;
    logic [31:0] fetch_count;
    logic [31:0] flush_count;

    logic       s_arst_n;
    logic       s_enable;
    logic       s_stall;
    logic       s_redirect_valid;
    logic [7:0] s_redirect_pc;
    logic [7:0] s_imem_addr;
    logic [7:0] s_imem_rdata;
    logic [7:0] s_instr;
    logic [7:0] s_updated_pc;
    logic [7:0] s_current_pc;
    logic       s_valid;
    logic [7:0] s_fetch_count;
    logic [7:0] s_flush_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_stage #(.DATA_W(32), .RESET_PC(32'h0), .PC_STEP(4)) u_dut (
        .clk               (clk),
        .arst_n            (arst_n),
        .enable            (enable),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .instruction_if_id (instruction_if_id),
        .updated_pc_if_id  (updated_pc_if_id),
        .current_pc_if_id  (current_pc_if_id),
        .valid_if_id       (valid_if_id),
        .fetch_count       (fetch_count),
        .flush_count       (flush_count)
    );

    fetch_stage #(.DATA_W(8), .RESET_PC(8'h0), .PC_STEP(4)) u_small (
        .clk               (clk),
        .arst_n            (s_arst_n),
        .enable            (s_enable),
        .stall             (s_stall),
        .redirect_valid    (s_redirect_valid),
        .redirect_pc       (s_redirect_pc),
        .imem_addr         (s_imem_addr),
        .imem_rdata        (s_imem_rdata),
        .instruction_if_id (s_instr),
        .updated_pc_if_id  (s_updated_pc),
        .current_pc_if_id  (s_current_pc),
        .valid_if_id       (s_valid),
        .fetch_count       (s_fetch_count),
        .flush_count       (s_flush_count)
    );

    // Instruction memory: fixed word at address 0, hashed contents elsewhere.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2008_0005 : ((a * 32'h9E37_79B1) ^ 32'h0BAD_F00D);
    endfunction

    assign imem_rdata   = mem_fn(imem_addr);
    assign s_imem_rdata = s_imem_addr ^ 8'h5A;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] upd;
        logic [31:0] cur;
        logic        valid;
        logic [31:0] fc;
        logic [31:0] flc;
    } exp_t;

    exp_t sb_q[$];
    exp_t m;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        m.pc = 32'h0; m.instr = 32'h0; m.upd = 32'h0; m.cur = 32'h0;
        m.valid = 1'b0; m.fc = 32'h0; m.flc = 32'h0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue what the IF/ID state must be after the edge.
    task automatic step(input logic en, input logic st, input logic rv, input logic [31:0] rpc);
        enable         = en;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (en) begin
            if (rv) begin
                m.pc    = rpc - (rpc % 32'd4);
                m.instr = 32'h0; m.upd = 32'h0; m.cur = 32'h0; m.valid = 1'b0;
                m.flc   = sat_inc(m.flc);
            end else if (!st) begin
                m.instr = mem_fn(m.pc);
                m.cur   = m.pc;
                m.upd   = m.pc + 32'd4;
                m.pc    = m.pc + 32'd4;
                m.valid = 1'b1;
                m.fc    = sat_inc(m.fc);
            end
        end
        sb_q.push_back(m);
    endtask

    task automatic do_reset();
        #2 arst_n = 1'b0;
        #1;
        check("reset_imem_addr", imem_addr, 32'h0);
        check("reset_valid", {31'h0, valid_if_id}, 32'h0);
        check("reset_instr", instruction_if_id, 32'h0);
        check("reset_fetch_count", fetch_count, 32'h0);
        check("reset_flush_count", flush_count, 32'h0);
        model_reset();
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    // Monitor: compares the DUT against the oldest queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                vectors++;
                if (imem_addr !== e.pc || instruction_if_id !== e.instr ||
                    updated_pc_if_id !== e.upd || current_pc_if_id !== e.cur ||
                    valid_if_id !== e.valid || fetch_count !== e.fc || flush_count !== e.flc) begin
                    miscompares++;
                    $display("FAIL ifid_state @%0t: got pc=%h ins=%h upd=%h cur=%h v=%b fc=%h flc=%h expected pc=%h ins=%h upd=%h cur=%h v=%b fc=%h flc=%h",
                             $time, imem_addr, instruction_if_id, updated_pc_if_id, current_pc_if_id,
                             valid_if_id, fetch_count, flush_count,
                             e.pc, e.instr, e.upd, e.cur, e.valid, e.fc, e.flc);
                end
            end
        end
    end

    initial begin
        arst_n = 1'b0; enable = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        s_arst_n = 1'b0; s_enable = 1'b0; s_stall = 1'b0; s_redirect_valid = 1'b0; s_redirect_pc = 8'h0;
        model_reset();
        #1;
        check("por_imem_addr", imem_addr, 32'h0);
        check("por_valid", {31'h0, valid_if_id}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        arst_n   = 1'b1;
        s_arst_n = 1'b1;

        // Sequential fetch from 0, then stall twice at 0xC, then advance.
        step(1, 0, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin @(negedge clk); step(1, 0, 0, 32'h0); end
        for (int i = 0; i < 2; i++) begin @(negedge clk); step(1, 1, 0, 32'h0); end
        @(negedge clk); step(1, 0, 0, 32'h0);
        // Redirect wins over stall; misaligned target is word aligned.
        @(negedge clk); step(1, 1, 1, 32'h0000_0103);
        @(negedge clk); step(1, 0, 0, 32'h0);
        @(negedge clk); step(1, 0, 0, 32'h0);
        // Enable low ignores redirect.
        for (int i = 0; i < 5; i++) begin @(negedge clk); step(0, 0, 1, 32'h0000_0200); end
        @(negedge clk); step(1, 0, 0, 32'h0);
        // PC wrap at the top of the address space.
        @(negedge clk); step(1, 0, 1, 32'hFFFF_FFFD);
        for (int i = 0; i < 3; i++) begin @(negedge clk); step(1, 0, 0, 32'h0); end

        for (int i = 0; i < 2000; i++) begin
            logic [31:0] rpc;
            @(negedge clk);
            if (i % 500 == 250) do_reset();
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, rpc);
        end
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);

        // Narrow instance: drive counters into saturation.
        s_enable = 1'b1;
        repeat (254) @(negedge clk);
        #1 check("small_fetch_254", {24'h0, s_fetch_count}, 32'd254);
        repeat (10) @(negedge clk);
        #1 check("small_fetch_sat", {24'h0, s_fetch_count}, 32'd255);
        check("small_pc_wrapped", {24'h0, s_imem_addr}, 32'h20);
        s_redirect_valid = 1'b1;
        s_redirect_pc    = 8'hFF;
        repeat (260) @(negedge clk);
        #1 check("small_flush_sat", {24'h0, s_flush_count}, 32'd255);
        check("small_redirect_pc", {24'h0, s_imem_addr}, 32'hFC);
        check("small_bubble_valid", {31'h0, s_valid}, 32'h0);
        check("small_bubble_instr", {24'h0, s_instr}, 32'h0);
        check("small_bubble_pcs", {16'h0, s_updated_pc, s_current_pc}, 32'h0);
        check("small_fetch_hold", {24'h0, s_fetch_count}, 32'd255);
        s_redirect_valid = 1'b0;
        s_stall          = 1'b1;
        repeat (3) @(negedge clk);
        #1 check("small_stall_hold", {24'h0, s_imem_addr}, 32'hFC);

        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
